// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared constants and elaboration helpers for the pipelined adder.
//   ADDER_WIDTH  : default operand/result width in bits
//   ADDER_STAGES : default number of pipeline stages
//   chunk_width  : bits added per stage (WIDTH / STAGES)
//   split_ok     : true when WIDTH splits evenly into STAGES >= 1 chunks
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int ADDER_WIDTH  = 16;
  localparam int ADDER_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_if
// Operand and result bundle for pipelined_adder.
//   in_valid / in_ready       : operand handshake (producer -> adder)
//   a, b, cin, sub            : operands and mode, qualified by in_valid
//   out_valid / out_ready     : result handshake (adder -> consumer)
//   sum, cout, ovf            : result fields, qualified by out_valid
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds valid and its payload
// steady until that transfer; ready may depend combinationally on the other
// side's valid, never the other way round.
// Modports: master = operand producer / result consumer, slave = the adder.
// ---------------------------------------------------------------------------
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk.sv
// ---------------------------------------------------------------------------
// adder_chunk
// CHUNK-bit combinational ripple-carry adder built from full-adder equations.
//   a_i, b_i : chunk operands
//   c_i      : carry into bit 0
//   sum_o    : chunk sum
//   cout_o   : carry out of the chunk MSB
//   cmsb_o   : carry into the chunk MSB (signed overflow needs it)
// ---------------------------------------------------------------------------
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry[0] = c_i;
    sum_o    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// chunks; one result per clock, valid/ready on both sides, global stall.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, dominates all other inputs
//   bus  : pipelined_adder_if slave (operands in, result out)
// Outputs come straight from the last stage registers; in_ready is the only
// combinational output and depends on out_valid/out_ready alone.
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES (STAGES >= 1)");
  end

  // Per-stage state. acc holds the partial result: chunks below and at the
  // stage index are finished sum bits, chunks above are still operand A.
  // opb is the (already inverted for subtract) B operand carried along.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0]            cmsb_q,  cmsb_d;
  logic [STAGES-1:0][WIDTH-1:0] acc_q,   acc_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_q,   opb_d;

  logic stall;

  // A valid result that nobody takes freezes the whole pipe.
  assign stall        = valid_q[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid;
    logic             src_carry;
    logic [WIDTH-1:0] src_acc;
    logic [WIDTH-1:0] src_opb;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_src_in
      // Subtract is A + ~B + 1, so cin is overridden when sub=1.
      assign src_valid = bus.in_valid;
      assign src_acc   = bus.a;
      assign src_opb   = bus.b ^ {WIDTH{bus.sub}};
      assign src_carry = bus.sub | bus.cin;
    end else begin : g_src_prev
      assign src_valid = valid_q[k-1];
      assign src_acc   = acc_q[k-1];
      assign src_opb   = opb_q[k-1];
      assign src_carry = carry_q[k-1];
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i    (src_acc[k*CHUNK +: CHUNK]),
      .b_i    (src_opb[k*CHUNK +: CHUNK]),
      .c_i    (src_carry),
      .sum_o  (chunk_sum),
      .cout_o (chunk_cout),
      .cmsb_o (chunk_cmsb)
    );

    // Overwrite operand chunk k with its sum; other chunks pass through.
    always_comb begin
      merged                   = src_acc;
      merged[k*CHUNK +: CHUNK] = chunk_sum;
    end

    assign valid_d[k] = src_valid;
    assign acc_d[k]   = merged;
    assign opb_d[k]   = src_opb;
    assign carry_d[k] = chunk_cout;
    assign cmsb_d[k]  = chunk_cmsb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = acc_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  // Only the last chunk's carry-into-MSB is the word's carry-into-MSB.
  assign bus.ovf       = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];

  // Last-stage B and the inner stages' MSB carries are never consumed.
  logic unused_bits;
  assign unused_bits = ^{opb_q[STAGES-1], cmsb_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed
// vector table, backpressure, bubble, reset-in-flight and random traffic,
// with an arithmetic reference model feeding an expected-result queue.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W      = 16;
  localparam int STAGES = 4;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int out_count = 0;

  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint ua, ub, sa, sb, full, sres;
    logic c, o;
    logic [W-1:0] s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + (cin ? longint'(1) : longint'(0));
      c    = (full >= (longint'(1) << W));
      sres = sa + sb + (cin ? longint'(1) : longint'(0));
    end
    s = full[W-1:0];
    o = (sres > MAXS) || (sres < MINS);
    return {o, c, s};
  endfunction

  // ---------------- scoreboard (samples at negedge) ----------------
  bit           prev_stall = 1'b0;
  logic [W+2:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(bus.out_valid), 32'(prev_out[W+2]));
        chk("stall_hold_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(prev_out[W+1:0]));
      end
      if (bus.out_valid && !bus.out_ready)
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("sb_sum",  32'(bus.sum),  32'(e[W-1:0]));
          chk("sb_cout", 32'(bus.cout), 32'(e[W]));
          chk("sb_ovf",  32'(bus.ovf),  32'(e[W+1]));
        end
        out_count++;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until accepted. Call just after a posedge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Single isolated operation: checks latency and the table's own results.
  task automatic apply_vec(input vec_t v, input string tag);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.a = v.a;
    bus.b = v.b;
    bus.cin = v.cin;
    bus.sub = v.sub;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
    if (got) begin
      chk({tag, "_sum"},  32'(bus.sum),  32'(v.sum));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
      chk({tag, "_ovf"},  32'(bus.ovf),  32'(v.ovf));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- test sequence ----------------
  vec_t vecs[10];

  initial begin
    int base;
    bit acc_last;

    vecs[0] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vecs[1] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, sum:16'h8000, cout:1'b0, ovf:1'b1};
    vecs[2] = '{a:16'h1234, b:16'h4321, cin:1'b1, sub:1'b0, sum:16'h5556, cout:1'b0, ovf:1'b0};
    vecs[3] = '{a:16'h0005, b:16'h0007, cin:1'b1, sub:1'b1, sum:16'hFFFE, cout:1'b0, ovf:1'b0};
    vecs[4] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'h7FFF, cout:1'b1, ovf:1'b1};
    vecs[5] = '{a:16'h0000, b:16'h0000, cin:1'b1, sub:1'b0, sum:16'h0001, cout:1'b0, ovf:1'b0};
    vecs[6] = '{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, sum:16'h0000, cout:1'b1, ovf:1'b1};
    vecs[7] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b0, sub:1'b1, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vecs[8] = '{a:16'h0000, b:16'h0001, cin:1'b0, sub:1'b1, sum:16'hFFFF, cout:1'b0, ovf:1'b0};
    vecs[9] = '{a:16'h00FF, b:16'h0F01, cin:1'b0, sub:1'b0, sum:16'h1000, cout:1'b0, ovf:1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sum",       32'(bus.sum),       32'd0);
    chk("reset_cout",      32'(bus.cout),      32'd0);
    chk("reset_ovf",       32'(bus.ovf),       32'd0);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);

    // Directed vectors.
    for (int i = 0; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    drain();

    // Backpressure: 8 back-to-back adds, consumer stalls 3 cycles.
    base = out_count;
    bus.out_ready = 1'b1;
    step();
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(i), 16'h0100, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          seen = bus.out_valid;
        end
        chk("bp_first_result", 32'(seen), 32'd1);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_stall_in_ready",  32'(bus.in_ready),  32'd0);
          chk("bp_stall_out_valid", 32'(bus.out_valid), 32'd1);
          step();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_result_count", 32'(out_count - base), 32'd8);

    // Bubbles: in_valid 1/0 pattern reappears STAGES cycles later.
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8 + STAGES + 1; j++) begin
      bit exp_v;
      step();
      bus.in_valid = (j < 8) && (j % 2 == 0);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.cin = 1'($urandom_range(0, 1));
      bus.sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_v = (j >= STAGES) && (j - STAGES < 8) && ((j - STAGES) % 2 == 0);
      chk($sformatf("bubble_out_valid_c%0d", j), 32'(bus.out_valid), 32'(exp_v));
    end
    bus.in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure.
    acc_last = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (!bus.in_valid || acc_last) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
        bus.b   = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_last = bus.in_valid && bus.in_ready;
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.in_valid = 1'b1;
      bus.a = W'(16'h1000 + i);
      bus.b = W'(16'h0010 * i);
      bus.cin = 1'b0;
      bus.sub = 1'b0;
    end
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'd0);
    chk("midrst_cout",      32'(bus.cout),      32'd0);
    chk("midrst_ovf",       32'(bus.ovf),       32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    apply_vec('{a:16'h0002, b:16'h0003, cin:1'b0, sub:1'b0, sum:16'h0005, cout:1'b0, ovf:1'b0},
              "post_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the team's gate-level full adder. Adds or subtracts two WIDTH-bit operands by splitting the carry chain into STAGES registered chunks, giving one result per clock at full throughput. Sits between operand-producing logic and downstream consumers with a valid/ready handshake, carry in/out and signed overflow.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Each stage adds one chunk of CHUNK = WIDTH/STAGES bits. STAGES ≥ 1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present on this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A−B, computed as A + ~B + 1.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective B: b XOR {WIDTH{sub}}. Effective carry-in: sub ? 1 : cin.
- Stage k (0..STAGES−1):
  - Adds chunk k of A and effective B with the carry registered from stage k−1. Stage 0 uses the effective carry-in.
  - Registers the chunk sum and carry-out.
  - Forwards the not-yet-added upper operand chunks and the already-computed lower sum chunks.
- The last stage drives sum, cout and ovf directly from registers. There is no combinational path from inputs to outputs.
- Each stage has a valid bit that travels with its data.
- Backpressure uses a global stall:
  - stall = out_valid && !out_ready.
  - While stalled, every stage register holds its value.
  - in_ready = !stall.
- A transfer in occurs when in_valid && in_ready. A transfer out occurs when out_valid && out_ready.
- Bubbles (in_valid=0) propagate as invalid stages. Their data is don't-care but must not corrupt valid stages.
- Results leave in acceptance order. No reordering, duplication or loss.

## Timing
- Latency: an operand accepted at rising edge t appears with out_valid=1 after edge t+STAGES−1. It is visible in the cycle following that edge, with no stalls in between.
- With STAGES=1 the result is visible the cycle after acceptance.
- Throughput: one operation per cycle while out_ready=1.
- Stall behaviour:
  - sum, cout, ovf and out_valid stay constant while out_valid=1 and out_ready=0.
  - in_ready drops in the same cycle, combinationally from out_valid and out_ready.
- out_ready=1 with out_valid=0 has no effect.
- Simultaneous transfer in and out in one cycle is legal. The pipeline advances by one stage.
- Reset:
  - Registers at the edge where rst=1; rst dominates every other input.
  - Clears all stage valid bits and data.
  - Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Reset mid-operation discards all in-flight results; none appear afterwards.
- Wrap-around: the sum is modulo 2^WIDTH and cout carries the lost bit. 0xFFFF+1 gives 0x0000 with cout=1.

## Structure
- Package adder_pkg holds:
  - default constants ADDER_WIDTH=16 and ADDER_STAGES=4.
  - a function computing CHUNK, used for elaboration checks.
- Elaboration check: WIDTH % STAGES == 0, otherwise a fatal error.
- One sub-module, adder_chunk:
  - Parametrised CHUNK-bit combinational ripple-carry add.
  - Built from the full-adder equations: sum = a^b^c, carry = ab | c(a^b).
  - Outputs: sum, carry-out and carry-into-MSB (the last one for ovf).
  - Instantiated once per stage inside a generate loop.
- Top level pipelined_adder contains only the stage registers, valid chain and stall logic.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Add with wrap: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow and carry-in:
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0x1234+0x4321 with cin=1 → sum=0x5556, cout=0, ovf=0.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0 (cin ignored).
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: issue 8 back-to-back adds (i+0x0100, i=0..7). Hold out_ready=0 for 3 cycles after the first result → in_ready=0 during the stall, outputs stable, all 8 results emerge in order, none lost or duplicated.
- Bubbles: alternate in_valid 1/0 → out_valid shows the same 1/0 pattern delayed 4 cycles, with correct sums.
- Reset mid-stream: 3 operations in flight, assert rst for one cycle → next cycle out_valid=0, sum=0, in_ready=1; no stale result ever appears; a new add 2+3 returns 5 after 4 cycles.
